// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } mdu_state_e;

  // Encoding matches funct[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {
    OP_MUL,
    OP_MULU,
    OP_DIV,
    OP_DIVU
  } mdu_op_e;

  localparam int ALUOP_WIRENUM = 2;
  localparam logic [ALUOP_WIRENUM-1:0] ALUOP_R = 2'b10;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f == FUNC_MFHI) || (f == FUNC_MTHI) || (f == FUNC_MFLO) ||
           (f == FUNC_MTLO) || (f == FUNC_MULT) || (f == FUNC_MULTU) ||
           (f == FUNC_DIV)  || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage bundle between the pipeline and the MDU: instruction in, stall and HI/LO read data out.
interface mdu_if import mdu_pkg::*; #(parameter int WIDTH = 32);
  logic                     valid;
  logic [ALUOP_WIRENUM-1:0] ALUOp;
  logic [5:0]               funct;
  logic [WIDTH-1:0]         op_a;
  logic [WIDTH-1:0]         op_b;
  logic                     stall;
  logic                     busy;
  logic                     mf_sel;
  logic [WIDTH-1:0]         hilo_rdata;

  modport master (
    output valid, ALUOp, funct, op_a, op_b,
    input  stall, busy, mf_sel, hilo_rdata
  );

  modport slave (
    input  valid, ALUOp, funct, op_a, op_b,
    output stall, busy, mf_sel, hilo_rdata
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Iterative datapath: WIDTH shift-add or restoring-divide steps on magnitudes, sign fix on the output.
// Results are valid combinationally once the last step has been taken; no backpressure.
module mdu_iter_core import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  mdu_op_e          kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cnt_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_q, rneg_q;

  logic             signed_op, is_div_in, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = (kind == OP_MUL) || (kind == OP_DIV);
    is_div_in = (kind == OP_DIV) || (kind == OP_DIVU);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // hi_q is the upper accumulator / partial remainder; lo_q holds the multiplier / dividend-quotient.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, dsr_q};
    if (is_div_q) begin
      nxt_hi = div_ge ? (div_shift[WIDTH-1:0] - dsr_q) : div_shift[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= is_div_in ? a_mag : b_mag;
      dsr_q    <= is_div_in ? b_mag : a_mag;
      cnt_q    <= CW'(WIDTH - 1);
      is_div_q <= is_div_in;
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
    end else if (step) begin
      hi_q <= nxt_hi;
      lo_q <= nxt_lo;
      if (cnt_q != '0)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    cnt_zero = (cnt_q == '0);
    if (is_div_q) begin
      res_lo = neg_q  ? -lo_q : lo_q;
      res_hi = rneg_q ? -hi_q : hi_q;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// MDU sequencer: decodes MDU funct codes, owns HI/LO, runs mul/div in WIDTH+2 cycles from accept to result.
// Stalls the pipeline only when an MDU instruction arrives while busy; other instructions flow freely.
module mdu_seq import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  mdu_state_e       state, state_nxt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             hit, accept, is_muldiv, start, step, cnt_zero;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    hit       = bus.valid && (bus.ALUOp == ALUOP_R) && is_mdu_funct(bus.funct);
    is_muldiv = (bus.funct[5:2] == 4'b0110);
    accept    = hit && (state == S_IDLE);
    start     = accept && is_muldiv;
    step      = (state == S_RUN);
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.stall  = hit && (state != S_IDLE);
  assign bus.mf_sel = accept && ((bus.funct == FUNC_MFHI) || (bus.funct == FUNC_MFLO));

  always_comb begin
    bus.hilo_rdata = '0;
    if (bus.mf_sel)
      bus.hilo_rdata = (bus.funct == FUNC_MFHI) ? hi_q : lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)    state_nxt = S_RUN;
      S_RUN:  if (cnt_zero) state_nxt = S_FIX;
      S_FIX:                state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // MT* can only be accepted in IDLE, so it never collides with the FIX write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == S_FIX) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (accept && (bus.funct == FUNC_MTHI)) begin
      hi_q <= bus.op_a;
    end else if (accept && (bus.funct == FUNC_MTLO)) begin
      lo_q <= bus.op_a;
    end
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step     (step),
    .kind     (mdu_op_e'(bus.funct[1:0])),
    .a        (bus.op_a),
    .b        (bus.op_b),
    .cnt_zero (cnt_zero),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: arithmetic reference model checked every cycle, plus directed literal results.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain 64-bit arithmetic, timing as a busy countdown.
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic [2*W-1:0] m_res = '0;
  int             m_left = 0;

  function automatic bit tb_hit();
    return bus.valid && (bus.ALUOp == ALUOP_R) &&
           (bus.funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic [2*W-1:0] mdu_result(input logic [5:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] q, r;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = '0;
    r = '0;
    p = '0;
    case (f)
      6'h18: p = 64'(sa * sb);
      6'h19: p = 64'(a) * 64'(b);
      6'h1A: begin
        if (b == '0) begin
          q = a[W-1] ? W'(1) : '1;
          r = a;
        end else begin
          q = W'(sa / sb);
          r = W'(sa % sb);
        end
        p = {r, q};
      end
      default: begin
        if (b == '0) begin
          q = '1;
          r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_res[2*W-1:W];
        m_lo <= m_res[W-1:0];
      end
    end else if (tb_hit()) begin
      case (bus.funct)
        6'h11: m_hi <= bus.op_a;
        6'h13: m_lo <= bus.op_a;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          m_res  <= mdu_result(bus.funct, bus.op_a, bus.op_b);
          m_left <= W + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit h, eb, acc, emf;
      logic [W-1:0] erd;
      h   = tb_hit();
      eb  = (m_left > 0);
      acc = h && !eb;
      emf = acc && ((bus.funct == 6'h10) || (bus.funct == 6'h12));
      erd = emf ? ((bus.funct == 6'h10) ? m_hi : m_lo) : '0;
      check("cyc_busy",   64'(bus.busy),       64'(eb));
      check("cyc_stall",  64'(bus.stall),      64'(h && eb));
      check("cyc_mf_sel", 64'(bus.mf_sel),     64'(emf));
      check("cyc_rdata",  64'(bus.hilo_rdata), 64'(erd));
    end
  end

  task automatic drive(input bit v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.valid = v;
    bus.ALUOp = ALUOP_R;
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1 drive(1'b0, 6'h00, '0, '0);
  endtask

  // Presents an instruction and holds it until accepted; returns how many cycles it stalled.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int stalls);
    @(posedge clk);
    #1 drive(1'b1, f, a, b);
    #1;
    stalls = 0;
    while (bus.stall && stalls < 200) begin
      @(posedge clk);
      #2;
      stalls++;
    end
    if (bus.stall) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: funct %h still stalled after %0d cycles, required accept", f, stalls);
    end
  endtask

  task automatic read(input logic [5:0] f, input logic [W-1:0] exp, input string name);
    int st;
    issue(f, '0, '0, st);
    check(name, 64'(bus.hilo_rdata), 64'(exp));
    check({name, "_sel"}, 64'(bus.mf_sel), 64'd1);
  endtask

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a, b, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[7] = '{
    '{6'h18, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{6'h19, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE},
    '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
    '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{6'h1A, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2},
    '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}
  };

  initial begin
    int st, nb;
    drive(1'b0, 6'h00, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(bus.busy),       64'd0);
    check("rst_stall",  64'(bus.stall),      64'd0);
    check("rst_mf_sel", 64'(bus.mf_sel),     64'd0);
    check("rst_rdata",  64'(bus.hilo_rdata), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    read(6'h10, '0, "rst_hi");
    read(6'h12, '0, "rst_lo");

    // MFLO presented the cycle after MULT is accepted: stalls for every busy cycle.
    issue(vecs[0].f, vecs[0].a, vecs[0].b, st);
    issue(6'h12, '0, '0, st);
    check("mflo_stall_cycles", 64'(st), 64'(W + 1));
    check("mflo_after_mult", 64'(bus.hilo_rdata), 64'hFFFFFFFE);
    read(6'h10, 32'hFFFFFFFF, "mult_hi");

    for (int i = 1; i < 7; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, st);
      read(6'h12, vecs[i].exp_lo, $sformatf("vec%0d_lo", i));
      read(6'h10, vecs[i].exp_hi, $sformatf("vec%0d_hi", i));
    end

    // Non-MDU instruction while busy must not stall.
    issue(6'h18, 32'd3, 32'd5, st);
    idle_cycle();
    @(posedge clk);
    #1 drive(1'b1, 6'h20, 32'd1, 32'd2);
    #1;
    check("add_no_stall", 64'(bus.stall), 64'd0);
    check("add_busy",     64'(bus.busy),  64'd1);
    read(6'h12, 32'd15, "small_lo");
    read(6'h10, 32'd0,  "small_hi");

    // MFHI with a non-R ALUOp is not an MDU instruction.
    @(posedge clk);
    #1 drive(1'b1, 6'h10, '0, '0);
    bus.ALUOp = 2'b00;
    #1;
    check("non_r_mf_sel", 64'(bus.mf_sel), 64'd0);

    issue(6'h11, 32'h1234, '0, st);
    read(6'h10, 32'h1234, "mthi_mfhi");
    check("mthi_busy", 64'(bus.busy), 64'd0);
    issue(6'h13, 32'hCAFE0001, '0, st);
    read(6'h12, 32'hCAFE0001, "mtlo_mflo");

    // Reset in cycle 10 of a DIVU discards it.
    issue(6'h1B, 32'd100, 32'd7, st);
    repeat (9) idle_cycle();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    read(6'h10, '0, "rst_mid_hi");
    read(6'h12, '0, "rst_mid_lo");

    issue(6'h18, 32'd7, 32'hFFFFFFFD, st);
    nb = 0;
    for (int c = 0; c < 200; c++) begin
      idle_cycle();
      #1;
      if (!bus.busy) break;
      nb++;
    end
    check("post_rst_busy_cycles", 64'(nb), 64'(W + 1));
    read(6'h12, 32'hFFFFFFEB, "post_rst_lo");
    read(6'h10, 32'hFFFFFFFF, "post_rst_hi");

    idle_cycle();
    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised multiply/divide sequencer: the multi-cycle companion to the ALU control decode. It decodes the MDU subset of R-type funct codes (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) and runs an iterative WIDTH-cycle shift-add multiply or restoring divide. It owns the HI/LO registers and raises a stall toward the pipeline while an operation is in flight. It sits in EX beside the ALU; its read data is muxed into the EX result when `mf_sel` is high.

## Interface
- WIDTH, 32, operand/HI/LO width; must be ≥ 4 and a power of two.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  instruction in EX is real (not a bubble/flushed slot).
- ALUOp  in  `ALUOp_WIRENUM  main-decoder ALU op; MDU decode is active only when equal to `ALUOp_R.
- funct  in  6  instruction funct field.
- op_a  in  WIDTH  rs value (multiplicand/dividend/MT source).
- op_b  in  WIDTH  rt value (multiplier/divisor).
- stall  out  1  combinational; holds IF/ID/EX when an MDU instruction is presented while busy.
- busy  out  1  registered; high whenever the FSM is not in IDLE.
- mf_sel  out  1  combinational; current instruction is MFHI/MFLO and is accepted this cycle.
- hilo_rdata  out  WIDTH  combinational; HI for MFHI, LO for MFLO, else 0.

## Operation
- mdu_hit = valid & (ALUOp == `ALUOp_R) & funct ∈ {MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B}.
- stall = mdu_hit & busy. Non-MDU instructions never stall, even while busy.
- Accept = mdu_hit & ~busy.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on accepted MULT*/DIV*: latch magnitudes of op_a/op_b (signed ops take the absolute value; unsigned pass through), result-sign flags, and op kind; count = WIDTH-1.
  - RUN: one iteration per cycle. Multiply: shift-add of one multiplier bit into a 2·WIDTH accumulator. Divide: one restoring-subtract step producing one quotient bit. count decrements; RUN→FIX when count == 0.
  - FIX: apply sign correction, write HI/LO, then →IDLE.
- Signed multiply: negate the 2·WIDTH product if sign(a)^sign(b). MULTU: no correction.
- Signed divide: quotient truncated toward zero; quotient sign = sign(a)^sign(b); remainder sign = sign(a). LO = quotient, HI = remainder.
- Divide by zero: no exception. LO = all ones, HI = op_a (unsigned result before sign fix; signed applies the fix to the same raw values).
- Signed overflow (MIN ÷ −1): LO = MIN, HI = 0; falls out of the magnitude arithmetic.
- MTHI/MTLO accepted in IDLE: write op_a to HI/LO at the edge; visible the next cycle. FSM stays in IDLE.
- MFHI/MFLO accepted: hilo_rdata is the current register value, combinationally, in the same cycle.
- No abort: a flushed (valid=0) slot never starts an operation. An operation once started always completes.

## Timing
- Reset: state = IDLE, count = 0, HI = LO = 0, busy = 0; stall/mf_sel/hilo_rdata = 0 with valid = 0.
- MULT/DIV accepted in cycle 0: busy is high in cycles 1..WIDTH+1 (WIDTH RUN cycles plus 1 FIX cycle). HI/LO hold the new value from cycle WIDTH+2, the first cycle busy is low.
- A stalled MDU instruction is accepted in the first cycle busy = 0. Back-to-back MULT issue spacing is therefore WIDTH+2 cycles.
- rst during RUN/FIX: next cycle IDLE, HI/LO = 0, and the partial result is discarded.
- HI/LO hold between writes. The old values remain readable only via stall-free cycles; none occur while busy.

## Structure
- Shared package mdu_pkg: FSM state enum (IDLE/RUN/FIX), MDU op-kind enum (MUL, MULU, DIV, DIVU). The funct constants FUNC_MFHI..FUNC_DIVU go into the existing funct include alongside the other FUNC_ codes.
- One sub-module, mdu_iter_core: the WIDTH-parametrised iteration datapath (accumulator, partial remainder, counter, sign fix). mdu_seq keeps the decode, stall logic, FSM and HI/LO.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → after 34 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; MULTU same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 ÷ 2 (0xFFFFFFF9, 0x2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 7 ÷ 0 → LO = 0xFFFFFFFF, HI = 0x00000007.
- DIV 0x80000000 ÷ 0xFFFFFFFF → LO = 0x80000000, HI = 0, no hang.
- MULT accepted in cycle 0, MFLO presented in cycle 1 → stall high in cycles 1..33; MFLO accepted in cycle 34 with hilo_rdata = product LO; an ADD (funct 0x20) presented in cycle 2 sees stall = 0.
- MTHI 0x1234 then MFHI the next cycle → hilo_rdata = 0x1234, mf_sel = 1, busy never rises.
- rst asserted in cycle 10 of a DIVU → busy = 0 in cycle 11, HI = LO = 0, and a following MULT runs its full WIDTH+1 busy cycles correctly.
